// File: rtl/readout_pkg.sv
// ============================================================================
// Module : readout_pkg
// Brief  : Shared state encoding and sizing helper for result_readout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package readout_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    FIN      = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  // Wide enough to hold DATA_W, which covers NBITS-1 with the parity bit.
  function automatic int bitcnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/result_readout_serial_bit_timer.sv
// ============================================================================
// Module : serial_bit_timer
// Brief  : Per-bit divider; flags the end of each bit period and the SCLK
//          phase that will hold after the coming clock edge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module serial_bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_bit_end,
  output logic o_sclk_phase
);

  localparam int              CW     = $clog2(DIV);
  localparam logic [CW-1:0]   c_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]   c_HALF = CW'(DIV / 2);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_wrap;

  always_comb begin
    w_wrap    = i_en && (r_cnt == c_LAST);
    w_cnt_nxt = r_cnt;
    if (i_clr || w_wrap) begin
      w_cnt_nxt = '0;
    end else if (i_en) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  assign o_bit_end    = w_wrap;
  assign o_sclk_phase = (w_cnt_nxt >= c_HALF);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/result_readout.sv
// ============================================================================
// Module : result_readout
// Brief  : Captures the pipeline result on an OUT_STROBE rise and shifts it
//          out MSB-first with FRAME/SCLK; pulses DONE at frame end.
//          Optional macro READOUT_PARITY_EN appends an even-parity bit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module result_readout
  import readout_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIV    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              OUT_STROBE,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic              BUSY,
  output logic              FRAME,
  output logic              SDO,
  output logic              SCLK,
  output logic              DONE
);

`ifdef READOUT_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int            BW         = bitcnt_width(DATA_W);
  localparam logic [BW-1:0] c_BIT_LAST = BW'(NBITS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_strobe_q;
  logic [NBITS-1:0] r_shreg;
  logic [BW-1:0]    r_bitcnt;
  logic [NBITS-1:0] w_load;
  logic             w_rise;
  logic             w_capture;
  logic             w_bit_end;
  logic             w_sclk_phase;
  logic             w_last;

`ifdef READOUT_PARITY_EN
  assign w_load = {DATA_IN, ^DATA_IN};
`else
  assign w_load = DATA_IN;
`endif

  assign w_rise    = OUT_STROBE && !r_strobe_q;
  assign w_capture = (r_state == IDLE) && w_rise;
  assign w_last    = w_bit_end && (r_bitcnt == '0);

  serial_bit_timer #(
    .DIV (DIV)
  ) u_timer (
    .clk          (CLK),
    .rst          (RST),
    .i_en         (r_state == SHIFT),
    .i_clr        (w_capture),
    .o_bit_end    (w_bit_end),
    .o_sclk_phase (w_sclk_phase)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_rise)      w_state_nxt = SHIFT;
      SHIFT:    if (w_last)      w_state_nxt = FIN;
      FIN:      w_state_nxt = OUT_STROBE ? WAIT_LOW : IDLE;
      WAIT_LOW: if (!OUT_STROBE) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_strobe_q <= 1'b1;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      BUSY       <= 1'b0;
      FRAME      <= 1'b0;
      SDO        <= 1'b0;
      SCLK       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      r_strobe_q <= OUT_STROBE;
      BUSY       <= (w_state_nxt == SHIFT) || (w_state_nxt == FIN);
      FRAME      <= (w_state_nxt == SHIFT);
      DONE       <= (w_state_nxt == FIN);
      SCLK       <= (r_state == SHIFT) && (w_state_nxt == SHIFT) && w_sclk_phase;
      if (w_capture) begin
        r_shreg  <= w_load;
        r_bitcnt <= c_BIT_LAST;
        SDO      <= w_load[NBITS-1];
      end else if (w_bit_end) begin
        r_shreg <= {r_shreg[NBITS-2:0], 1'b0};
        SDO     <= w_last ? 1'b0 : r_shreg[NBITS-2];
        if (!w_last) begin
          r_bitcnt <= r_bitcnt - 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/result_readout.md
# result_readout

Serial readout for the three-stage compute pipeline. Sits downstream of the pipeline sequencer: it watches the sequencer's OUT_STROBE, captures the pipeline result word on the strobe's rising edge, and shifts it out MSB-first on a framed serial link with a generated bit clock. When the frame is complete it pulses DONE. It re-arms only after OUT_STROBE has returned low.

## Interface
Parameters:
- DATA_W, 16: result word width; minimum 2.
- DIV, 4: CLK cycles per serial bit; even, minimum 2.

Ports:
- CLK  in  1  system clock; every register uses the rising edge.
- RST  in  1  synchronous, active-high reset.
- OUT_STROBE  in  1  level from the sequencer; high while the result is valid.
- DATA_IN  in  DATA_W  result word; sampled only at capture.
- BUSY  out  1  high from capture until the end of the frame.
- FRAME  out  1  high while serial bits are being driven.
- SDO  out  1  serial data.
- SCLK  out  1  bit clock; the receiver samples SDO on the SCLK rising edge.
- DONE  out  1  one-cycle pulse at the end of the frame.

## Operation
- States:
  - IDLE: waiting for a strobe rising edge.
  - SHIFT: driving the frame.
  - FIN: one cycle, DONE asserted.
  - WAIT_LOW: OUT_STROBE is still high; waiting for it to drop.
- Edge detect: strobe_q is a register holding the previous OUT_STROBE. A rise is OUT_STROBE=1 and strobe_q=0.
- IDLE with a rise: load the shift register from DATA_IN, set the bit counter to NBITS-1, clear the divider, go to SHIFT.
  - NBITS = DATA_W, or DATA_W+1 with parity enabled.
- SHIFT:
  - The divider counts 0..DIV-1.
  - On wrap: shift left. If the bit counter is 0, go to FIN; otherwise decrement it.
- FIN: go to WAIT_LOW if OUT_STROBE=1, else go to IDLE.
- WAIT_LOW: go to IDLE when OUT_STROBE=0.
  - A strobe held high never starts a second frame.
- DATA_IN changes after capture have no effect on the frame.
- A rise seen outside IDLE is ignored. This cannot occur in normal use.
- All outputs are registered.

## Timing
- Reset values:
  - State = IDLE; strobe_q = 1, so a strobe already high through reset does not trigger a frame.
  - BUSY, FRAME, SDO, SCLK and DONE are all 0.
- Reset asserted mid-frame: on the next edge all outputs and state take their reset values. The frame is abandoned with no DONE pulse.
- Let capture edge = edge 0.
  - After edge 0: BUSY=1, FRAME=1, SDO = DATA_IN[DATA_W-1].
  - Bit k (k = 0..NBITS-1) is held on SDO from edge k·DIV to edge (k+1)·DIV.
- SCLK within each bit period:
  - 0 for the first DIV/2 cycles, 1 for the last DIV/2 cycles.
  - Exactly NBITS SCLK rising edges per frame.
- After edge NBITS·DIV: FRAME=0, SDO=0, SCLK=0, DONE=1, BUSY=1.
- After edge NBITS·DIV+1: DONE=0, BUSY=0.
- Capture-to-DONE latency is NBITS·DIV cycles. The earliest next capture is two edges after DONE, provided the strobe is low then high.

## Configuration
- Macro: READOUT_PARITY_EN.
- Defined: one even-parity bit is appended after the LSB.
  - Value = XOR of the captured word, computed at capture.
  - NBITS = DATA_W+1; FRAME covers the parity bit.
- Undefined: no parity logic; NBITS = DATA_W.

## Structure
Package readout_pkg holds:
- The state typedef (IDLE, SHIFT, FIN, WAIT_LOW, 2-bit encoding).
- A function computing the bit-counter width from DATA_W.

One sub-module is natural: serial_bit_timer.
- Contains the DIV divider.
- Outputs bit_end (wrap pulse) and sclk_phase.
- Enabled by SHIFT, cleared by capture or RST.

## Test plan
All scenarios use DATA_W=8 and DIV=4 unless stated otherwise.
- Reset: RST high for 3 cycles with OUT_STROBE high -> all outputs 0; release RST with strobe still high -> no frame.
- DATA_IN=8'hA5, strobe low then high:
  - FRAME high for 32 cycles; SDO sequence 1,0,1,0,0,1,0,1; 8 SCLK rises.
  - DONE pulse one cycle after the last bit period.
- Hold strobe high for 100 cycles after DONE -> no second frame. Drop strobe, raise it with DATA_IN=8'h3C -> second frame shifts 0,0,1,1,1,1,0,0.
- Change DATA_IN to 8'hFF at edge 5 of a frame captured with 8'h00 -> SDO stays 0 for the whole frame.
- Assert RST at edge 13 of an 8'hA5 frame -> outputs 0 on the next edge, no DONE; a new frame starts only after the strobe goes low then high.
- With READOUT_PARITY_EN and DIV=2:
  - 8'hA5 -> 9th bit 0, FRAME high 18 cycles.
  - 8'h07 -> 9th bit 1.
